// File: rtl/avm_loopback_fifo_if.sv
// Beat-stream bundle between the AXI slave bridge (master) and the loopback FIFO (slave).
// Write beats flow bridge -> FIFO; read beats flow FIFO -> bridge.
interface avm_loopback_fifo_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic                  avm_wr_vaild;
    logic [DATA_WIDTH-1:0] avm_wr_data;
    logic                  avm_wr_ready;
    logic                  avm_rd_ready;
    logic                  avm_rd_vaild;
    logic [DATA_WIDTH-1:0] avm_rd_data;

    modport master (
        output avm_wr_vaild,
        output avm_wr_data,
        output avm_rd_ready,
        input  avm_wr_ready,
        input  avm_rd_vaild,
        input  avm_rd_data
    );

    modport slave (
        input  avm_wr_vaild,
        input  avm_wr_data,
        input  avm_rd_ready,
        output avm_wr_ready,
        output avm_rd_vaild,
        output avm_rd_data
    );
endinterface

// File: rtl/avm_loopback_fifo.sv
// In-order loopback buffer: stores bridge write beats and replays them on the read-beat stream.
// First-word-fall-through with a registered output stage in front of a circular array.
module avm_loopback_fifo #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AFULL_LVL  = 12
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    flush,
    avm_loopback_fifo_if.slave      avm,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full,
    output logic [31:0]             wr_beats,
    output logic [31:0]             rd_beats
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);
    localparam logic [LW-1:0] AfullLvl = LW'(AFULL_LVL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  wr_ready_q;
    logic                  afull_q;
    logic [31:0]           wr_beats_q, rd_beats_q;

    logic push, pop, arr_nonempty, load_out, arr_rd, bypass, mem_we;

    // The output register holds one beat, so the array never exceeds DEPTH-1 entries and
    // pointer equality alone means "array empty".
    always_comb begin
        push         = avm.avm_wr_vaild & wr_ready_q;
        pop          = out_valid_q & avm.avm_rd_ready;
        arr_nonempty = (wr_ptr_q != rd_ptr_q);
        load_out     = ~out_valid_q | pop;
        arr_rd       = load_out & arr_nonempty;
        bypass       = load_out & ~arr_nonempty & push;
        mem_we       = push & ~bypass & ~flush;
        level_d      = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= avm.avm_wr_data;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            afull_q     <= 1'b0;
            wr_beats_q  <= '0;
            rd_beats_q  <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            if (mem_we) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (arr_rd) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                out_data_q <= mem_q[rd_ptr_q];
            end else if (bypass) begin
                out_data_q <= avm.avm_wr_data;
            end
            if (load_out) begin
                out_valid_q <= arr_nonempty | push;
            end
            level_q    <= level_d;
            wr_ready_q <= (level_d < DepthLvl);
            afull_q    <= (level_d >= AfullLvl);
            if (push) begin
                wr_beats_q <= wr_beats_q + 32'd1;
            end
            if (pop) begin
                rd_beats_q <= rd_beats_q + 32'd1;
            end
        end
    end

    assign avm.avm_wr_ready = wr_ready_q;
    assign avm.avm_rd_vaild = out_valid_q;
    assign avm.avm_rd_data  = out_data_q;
    assign level            = level_q;
    assign almost_full      = afull_q;
    assign wr_beats         = wr_beats_q;
    assign rd_beats         = rd_beats_q;
endmodule

// File: tb/tb_avm_loopback_fifo.sv
// Directed bench for avm_loopback_fifo: reset, FWFT latency, full/almost-full, streaming,
// backpressure, flush, counter wrap and mid-burst reset.
module tb_avm_loopback_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  level;
    logic        almost_full;
    logic [31:0] wr_beats, rd_beats;
    int          total = 0;
    int          bad = 0;

    avm_loopback_fifo_if #(.DATA_WIDTH(512)) avm ();

    avm_loopback_fifo #(
        .DATA_WIDTH (512),
        .DEPTH      (16),
        .AFULL_LVL  (12)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .flush         (flush),
        .avm           (avm),
        .level         (level),
        .almost_full   (almost_full),
        .wr_beats      (wr_beats),
        .rd_beats      (rd_beats)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] a5;
        logic         pat [5];
        logic [7:0]   exp_bp [5];
        a5 = {64{8'hA5}};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_bp = '{8'h31, 8'h32, 8'h32, 8'h32, 8'h33};

        rst_n = 1'b0;
        flush = 1'b0;
        avm.avm_wr_vaild = 1'b0;
        avm.avm_wr_data  = '0;
        avm.avm_rd_ready = 1'b0;
        step();
        step();
        chk("rst_wr_ready", 512'(avm.avm_wr_ready), 512'(0));
        chk("rst_rd_vaild", 512'(avm.avm_rd_vaild), 512'(0));
        chk("rst_level", 512'(level), 512'(0));
        chk("rst_rd_data", avm.avm_rd_data, 512'(0));
        chk("rst_afull", 512'(almost_full), 512'(0));
        rst_n = 1'b1;
        step();
        chk("rel_wr_ready", 512'(avm.avm_wr_ready), 512'(1));

        // Single beat through an empty FIFO, popped in the cycle it appears
        avm.avm_wr_vaild = 1'b1;
        avm.avm_wr_data  = a5;
        avm.avm_rd_ready = 1'b1;
        step();
        avm.avm_wr_vaild = 1'b0;
        chk("fwft_vaild", 512'(avm.avm_rd_vaild), 512'(1));
        chk("fwft_data", avm.avm_rd_data, a5);
        chk("fwft_level", 512'(level), 512'(1));
        step();
        chk("fwft_pop_vaild", 512'(avm.avm_rd_vaild), 512'(0));
        chk("fwft_pop_level", 512'(level), 512'(0));
        chk("fwft_wr_beats", 512'(wr_beats), 512'(1));
        chk("fwft_rd_beats", 512'(rd_beats), 512'(1));

        // Fill to 16 with no reader
        avm.avm_rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            avm.avm_wr_vaild = 1'b1;
            avm.avm_wr_data  = 512'(i);
            step();
            chk("fill_afull", 512'(almost_full), 512'((i + 1) >= 12));
            chk("fill_wr_ready", 512'(avm.avm_wr_ready), 512'((i + 1) < 16));
        end
        avm.avm_wr_data = 512'(99);
        step();
        chk("full_level", 512'(level), 512'(16));
        chk("full_wr_beats", 512'(wr_beats), 512'(17));
        avm.avm_wr_vaild = 1'b0;
        avm.avm_rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("drain_data", avm.avm_rd_data, 512'(j));
            chk("drain_vaild", 512'(avm.avm_rd_vaild), 512'(1));
            if (j == 0) chk("drain_wr_ready_pre", 512'(avm.avm_wr_ready), 512'(0));
            step();
            if (j == 0) chk("drain_wr_ready_post", 512'(avm.avm_wr_ready), 512'(1));
        end
        chk("drain_empty", 512'(avm.avm_rd_vaild), 512'(0));
        chk("drain_level", 512'(level), 512'(0));
        chk("drain_rd_beats", 512'(rd_beats), 512'(17));

        // Streaming: 1-beat prefill then push+pop every cycle
        avm.avm_rd_ready = 1'b0;
        avm.avm_wr_vaild = 1'b1;
        avm.avm_wr_data  = 512'(1000);
        step();
        for (int k = 0; k < 100; k++) begin
            avm.avm_rd_ready = 1'b1;
            avm.avm_wr_data  = 512'(1001 + k);
            chk("stream_data", avm.avm_rd_data, 512'(1000 + k));
            step();
            chk("stream_level", 512'(level), 512'(1));
        end
        avm.avm_wr_vaild = 1'b0;
        avm.avm_rd_ready = 1'b0;
        chk("stream_last", avm.avm_rd_data, 512'(1100));
        chk("stream_wr_beats", 512'(wr_beats), 512'(118));
        chk("stream_rd_beats", 512'(rd_beats), 512'(117));
        avm.avm_rd_ready = 1'b1;
        step();
        avm.avm_rd_ready = 1'b0;
        chk("stream_end_level", 512'(level), 512'(0));

        // Backpressure with three queued beats
        for (int m = 0; m < 3; m++) begin
            avm.avm_wr_vaild = 1'b1;
            avm.avm_wr_data  = 512'(8'h31 + m);
            step();
        end
        avm.avm_wr_vaild = 1'b0;
        for (int m = 0; m < 5; m++) begin
            avm.avm_rd_ready = pat[m];
            chk("bp_data", avm.avm_rd_data, 512'(exp_bp[m]));
            chk("bp_vaild", 512'(avm.avm_rd_vaild), 512'(1));
            step();
        end
        avm.avm_rd_ready = 1'b0;
        chk("bp_empty", 512'(avm.avm_rd_vaild), 512'(0));
        chk("bp_rd_beats", 512'(rd_beats), 512'(121));

        // Flush at level 5 with a simultaneous push and pop
        for (int m = 0; m < 5; m++) begin
            avm.avm_wr_vaild = 1'b1;
            avm.avm_wr_data  = 512'(8'h50 + m);
            step();
        end
        chk("pre_flush_level", 512'(level), 512'(5));
        avm.avm_wr_data  = 512'(8'h55);
        avm.avm_rd_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        avm.avm_wr_vaild = 1'b0;
        avm.avm_rd_ready = 1'b0;
        chk("flush_level", 512'(level), 512'(0));
        chk("flush_vaild", 512'(avm.avm_rd_vaild), 512'(0));
        chk("flush_wr_ready", 512'(avm.avm_wr_ready), 512'(0));
        chk("flush_wr_beats", 512'(wr_beats), 512'(126));
        chk("flush_rd_beats", 512'(rd_beats), 512'(121));
        step();
        chk("flush_wr_ready_back", 512'(avm.avm_wr_ready), 512'(1));

        // Write counter wrap via preload
        force dut.wr_beats_q = 32'hFFFF_FFFF;
        step();
        release dut.wr_beats_q;
        chk("preload", 512'(wr_beats), 512'(32'hFFFF_FFFF));
        avm.avm_wr_vaild = 1'b1;
        avm.avm_wr_data  = 512'(8'h77);
        step();
        chk("wrap_wr_beats", 512'(wr_beats), 512'(0));
        chk("wrap_data", avm.avm_rd_data, 512'(8'h77));

        // Reset mid-burst clears immediately
        avm.avm_wr_data = 512'(8'h78);
        step();
        avm.avm_wr_vaild = 1'b0;
        chk("burst_level", 512'(level), 512'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 512'(level), 512'(0));
        chk("mid_rst_vaild", 512'(avm.avm_rd_vaild), 512'(0));
        chk("mid_rst_wr_ready", 512'(avm.avm_wr_ready), 512'(0));
        chk("mid_rst_rd_data", avm.avm_rd_data, 512'(0));
        chk("mid_rst_rd_beats", 512'(rd_beats), 512'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_wr_ready", 512'(avm.avm_wr_ready), 512'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
